eeprom_blk_seq: RTL

//  Block-transfer sequencer upstream of the byte-level IIC controller (iic).

---
 rtl/eeprom_blk_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/eeprom_blk_seq.sv
// eeprom_blk_seq: block-transfer sequencer in front of the byte-level iic controller.
// Splits one host read/write request into single-byte iic commands with retry, write gap and watchdog.
module eeprom_blk_seq #(
    parameter logic [6:0]  DEV_ID    = 7'h50,
    parameter int          MAX_RETRY = 3,
    parameter logic [15:0] WR_GAP    = 16'd50000,
    parameter logic [23:0] WDOG      = 24'hFFFFFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       wr_mode,
    input  logic [7:0] base_addr,
    input  logic [8:0] length,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       seq_busy,
    output logic       done,
    output logic       err,
    output logic [7:0] err_addr,
    output logic [1:0] iic_cmd,
    output logic [7:0] iic_add,
    output logic [7:0] iic_dout,
    output logic [6:0] iic_dev_id,
    input  logic       iic_busy,
    input  logic       iic_fail,
    input  logic [7:0] iic_din
);
    localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WACK, S_WDONE, S_CHECK, S_PUSH, S_GAP, S_ERR, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [7:0]  cur_addr_q, cur_addr_d;
    logic [8:0]  rem_q, rem_d;
    logic [2:0]  retry_q, retry_d;
    logic [23:0] cnt_q, cnt_d;
    logic        to_q, to_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  rdat_q, rdat_d;
    logic        err_q, err_d;
    logic [7:0]  eaddr_q, eaddr_d;
    logic [7:0]  add_q, add_d;
    logic [1:0]  cmd_q, cmd_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic start_ok, fail_now, last, gap_end, wdog_end, advance;

    // A start landing in the done cycle sees busy_q=1 and is dropped.
    assign start_ok = start && (state_q == S_IDLE) && !busy_q;
    assign fail_now = iic_fail || to_q;
    assign last     = (rem_q == 9'd1);
    assign gap_end  = (cnt_q + 24'd1) >= {8'd0, WR_GAP};
    assign wdog_end = (cnt_q + 24'd1) >= WDOG;
    assign advance  = ((state_q == S_PUSH) && rd_ready) || ((state_q == S_GAP) && gap_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) begin
                         if (length == 9'd0) state_d = S_DONE;
                         else if (wr_mode)   state_d = S_FETCH;
                         else                state_d = S_ISSUE;
                     end
            S_FETCH: if (wr_valid) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WACK;
            S_WACK:  if (iic_busy) state_d = S_WDONE;
                     else if (cnt_q == 24'd3) state_d = S_CHECK;
            S_WDONE: if (!iic_busy) state_d = S_CHECK;
                     else if (wdog_end) state_d = S_ERR;
            S_CHECK: if (fail_now) state_d = (retry_q < MAX_R) ? S_ISSUE : S_ERR;
                     else          state_d = wr_q ? S_GAP : S_PUSH;
            S_PUSH:  if (rd_ready) state_d = last ? S_DONE : S_ISSUE;
            S_GAP:   if (gap_end)  state_d = last ? S_DONE : S_FETCH;
            S_ERR:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_d       = wr_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        retry_d    = retry_q;
        to_d       = 1'b0;
        dout_d     = dout_q;
        rdat_d     = rdat_q;
        err_d      = err_q;
        eaddr_d    = eaddr_q;
        add_d      = add_q;
        cmd_d      = 2'b00;
        done_d     = (state_q == S_DONE);
        busy_d     = (state_q == S_IDLE) ? start_ok : 1'b1;
        cnt_d      = ((state_d != state_q) || (state_q == S_IDLE)) ? 24'd0 : cnt_q + 24'd1;
        wr_ready   = (state_q == S_FETCH);
        rd_valid   = (state_q == S_PUSH);
        if (start_ok) begin
            wr_d       = wr_mode;
            cur_addr_d = base_addr;
            rem_d      = length;
            retry_d    = 3'd0;
            err_d      = 1'b0;
        end
        case (state_q)
            S_FETCH: if (wr_valid) dout_d = wr_data;
            S_ISSUE: begin
                cmd_d = wr_q ? 2'b10 : 2'b01;
                add_d = cur_addr_q;
            end
            // A missing busy acknowledge is folded into the normal retry path.
            S_WACK:  to_d = !iic_busy && (cnt_q == 24'd3);
            S_CHECK: if (fail_now) begin
                         if (retry_q < MAX_R) retry_d = retry_q + 3'd1;
                     end else begin
                         retry_d = 3'd0;
                         rdat_d  = iic_din;
                     end
            S_ERR:   begin
                err_d   = 1'b1;
                eaddr_d = cur_addr_q;
            end
            default: ;
        endcase
        if (advance) begin
            cur_addr_d = cur_addr_q + 8'd1;
            rem_d      = rem_q - 9'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= 1'b0;  cur_addr_q <= '0; rem_q <= '0;  retry_q <= '0;
            cnt_q <= '0;   to_q <= 1'b0;     dout_q <= '0; rdat_q <= '0;
            err_q <= 1'b0; eaddr_q <= '0;    add_q <= '0;  cmd_q <= '0;
            done_q <= 1'b0; busy_q <= 1'b0;
        end else begin
            wr_q <= wr_d;   cur_addr_q <= cur_addr_d; rem_q <= rem_d;   retry_q <= retry_d;
            cnt_q <= cnt_d; to_q <= to_d;             dout_q <= dout_d; rdat_q <= rdat_d;
            err_q <= err_d; eaddr_q <= eaddr_d;       add_q <= add_d;   cmd_q <= cmd_d;
            done_q <= done_d; busy_q <= busy_d;
        end
    end

    assign rd_data    = rdat_q;
    assign seq_busy   = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_addr   = eaddr_q;
    assign iic_cmd    = cmd_q;
    assign iic_add    = add_q;
    assign iic_dout   = dout_q;
    assign iic_dev_id = DEV_ID;
endmodule
